// File: rtl/addr_seq.sv
// addr_seq: memory-address sequencer for the LFSR pattern/sample memory.
// A start request walks addr from BASE to a runtime terminal address, either
// once (one-shot, ends in DONE) or repeatedly (wrap). Supports pause and abort.
// Optional feature macro: ADDR_SEQ_PASS_CNT_EN adds a saturating pass counter.
module addr_seq #(
  parameter int ADDR_W = 14,
  parameter int BASE   = 0,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st,
  input  logic              en,
  input  logic              mode,
  input  logic [ADDR_W-1:0] term,
  output logic [ADDR_W-1:0] addr,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic              done_p,
`ifdef ADDR_SEQ_PASS_CNT_EN
  output logic [PASS_W-1:0] pass_cnt,
`endif
  output logic              wrap_p
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  // Reject parameter sets that cannot work at elaboration time.
  if (ADDR_W < 1 || PASS_W < 1 || BASE < 0 ||
      (longint'(BASE) >= (longint'(1) << ADDR_W))) begin : g_param_check
    $error("addr_seq: bad parameters (ADDR_W/PASS_W must be >=1, BASE must fit in ADDR_W)");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic              done_d;
  logic              done_p_d;
  logic              wrap_p_d;
  logic [ADDR_W-1:0] term_q, term_d;
  logic              mode_q, mode_d;
  logic [ADDR_W:0]   term_diff;
  logic              term_below;

  // A terminal below BASE is detected by the borrow of term - BASE.
  assign term_diff  = {1'b0, term} - {1'b0, BASE_A};
  assign term_below = term_diff[ADDR_W];

  assign busy  = (state == RUN);
  assign valid = busy & en;

  // Next-state and next-output logic; st low overrides everything else.
  always_comb begin
    state_d  = state;
    addr_d   = addr;
    done_d   = done;
    done_p_d = 1'b0;
    wrap_p_d = 1'b0;
    term_d   = term_q;
    mode_d   = mode_q;
    case (state)
      IDLE: begin
        addr_d = BASE_A;
        done_d = 1'b0;
        if (st) begin
          state_d = RUN;
          term_d  = term_below ? BASE_A : term;
          mode_d  = mode;
        end
      end
      RUN: begin
        if (!st) begin
          state_d = IDLE;
          addr_d  = BASE_A;
          done_d  = 1'b0;
        end else if (en) begin
          if (addr != term_q) begin
            addr_d = addr + ADDR_W'(1);
          end else if (!mode_q) begin
            state_d  = DONE;
            done_d   = 1'b1;
            done_p_d = 1'b1;
          end else begin
            addr_d   = BASE_A;
            wrap_p_d = 1'b1;
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
        if (!st) begin
          state_d = IDLE;
          addr_d  = BASE_A;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = BASE_A;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, address, flag and captured-configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= BASE_A;
      done   <= 1'b0;
      done_p <= 1'b0;
      wrap_p <= 1'b0;
      term_q <= BASE_A;
      mode_q <= 1'b0;
    end else begin
      state  <= state_d;
      addr   <= addr_d;
      done   <= done_d;
      done_p <= done_p_d;
      wrap_p <= wrap_p_d;
      term_q <= term_d;
      mode_q <= mode_d;
    end
  end

`ifdef ADDR_SEQ_PASS_CNT_EN
  // Pass counter: cleared on start, counts completed passes, saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt <= '0;
    end else if (state == IDLE && st) begin
      pass_cnt <= '0;
    end else if ((done_p_d || wrap_p_d) && (pass_cnt != {PASS_W{1'b1}})) begin
      pass_cnt <= pass_cnt + PASS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_addr_seq.sv
// tb_addr_seq: directed self-checking bench for addr_seq (default parameters).
// Covers reset, one-shot, wrap, pause, abort, async reset and full-length runs.
module tb_addr_seq;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              st;
  logic              en;
  logic              mode;
  logic [ADDR_W-1:0] term;
  logic [ADDR_W-1:0] addr;
  logic              valid;
  logic              busy;
  logic              done;
  logic              done_p;
  logic              wrap_p;
`ifdef ADDR_SEQ_PASS_CNT_EN
  logic [7:0]        pass_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  addr_seq #(.ADDR_W(ADDR_W), .BASE(0), .PASS_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .st     (st),
    .en     (en),
    .mode   (mode),
    .term   (term),
    .addr   (addr),
    .valid  (valid),
    .busy   (busy),
    .done   (done),
    .done_p (done_p),
`ifdef ADDR_SEQ_PASS_CNT_EN
    .pass_cnt (pass_cnt),
`endif
    .wrap_p (wrap_p)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic e, input logic m,
                               input logic [ADDR_W-1:0] t);
    st   = s;
    en   = e;
    mode = m;
    term = t;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  int               ntrans;
  int               seqErr;
  logic             gotDone;
  logic [ADDR_W-1:0] lastAddr;

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    stepCycle();
    stepCycle();
    rst = 1'b0;
    stepCycle();

    // Reset / idle state
    checkOutput("rst_addr", 32'(addr), 0);
    checkOutput("rst_valid", 32'(valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_done_p", 32'(done_p), 0);
    checkOutput("rst_wrap_p", 32'(wrap_p), 0);
`ifdef ADDR_SEQ_PASS_CNT_EN
    checkOutput("rst_pass_cnt", 32'(pass_cnt), 0);
`endif

    // One-shot, term=5
    applyStimulus(1'b1, 1'b1, 1'b0, 14'd5);
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkOutput($sformatf("os_addr%0d", i), 32'(addr), 32'(i));
      checkOutput($sformatf("os_valid%0d", i), 32'(valid), 1);
      checkOutput($sformatf("os_done_p%0d", i), 32'(done_p), 0);
    end
    stepCycle();
    checkOutput("os_end_done_p", 32'(done_p), 1);
    checkOutput("os_end_done", 32'(done), 1);
    checkOutput("os_end_addr", 32'(addr), 5);
    checkOutput("os_end_valid", 32'(valid), 0);
    stepCycle();
    checkOutput("os_hold_done_p", 32'(done_p), 0);
    checkOutput("os_hold_done", 32'(done), 1);
    checkOutput("os_hold_addr", 32'(addr), 5);
`ifdef ADDR_SEQ_PASS_CNT_EN
    checkOutput("os_pass_cnt", 32'(pass_cnt), 1);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 14'd5);
    stepCycle();
    checkOutput("os_idle_addr", 32'(addr), 0);
    checkOutput("os_idle_done", 32'(done), 0);
    checkOutput("os_idle_busy", 32'(busy), 0);

    // Wrap, term=3: addr 0,1,2,3,0,... wrap_p when addr returns to 0
    applyStimulus(1'b1, 1'b1, 1'b1, 14'd3);
    for (int k = 1; k <= 13; k++) begin
      stepCycle();
      checkOutput($sformatf("wr_addr%0d", k), 32'(addr), 32'((k - 1) % 4));
      checkOutput($sformatf("wr_wrap_p%0d", k), 32'(wrap_p),
                  (k > 1 && ((k - 1) % 4) == 0) ? 1 : 0);
      checkOutput($sformatf("wr_done%0d", k), 32'(done), 0);
    end
`ifdef ADDR_SEQ_PASS_CNT_EN
    checkOutput("wr_pass_cnt", 32'(pass_cnt), 3);
`endif
    applyStimulus(1'b0, 1'b1, 1'b1, 14'd3);
    stepCycle();
    checkOutput("wr_idle_addr", 32'(addr), 0);

    // Pause at addr=2, late term/mode changes ignored
    applyStimulus(1'b1, 1'b1, 1'b0, 14'd5);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("pz_at2", 32'(addr), 2);
    applyStimulus(1'b1, 1'b0, 1'b1, 14'd1);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput($sformatf("pz_hold%0d", i), 32'(addr), 2);
      checkOutput($sformatf("pz_valid%0d", i), 32'(valid), 0);
    end
    en = 1'b1;
    for (int i = 3; i <= 5; i++) begin
      stepCycle();
      checkOutput($sformatf("pz_addr%0d", i), 32'(addr), 32'(i));
      checkOutput($sformatf("pz_wrap_p%0d", i), 32'(wrap_p), 0);
    end
    stepCycle();
    checkOutput("pz_done_p", 32'(done_p), 1);
    checkOutput("pz_done", 32'(done), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 14'd5);
    stepCycle();

    // Abort on terminal address
    applyStimulus(1'b1, 1'b1, 1'b0, 14'd5);
    for (int i = 0; i < 6; i++) stepCycle();
    checkOutput("ab_at5", 32'(addr), 5);
    st = 1'b0;
    stepCycle();
    checkOutput("ab_addr", 32'(addr), 0);
    checkOutput("ab_done_p", 32'(done_p), 0);
    checkOutput("ab_done", 32'(done), 0);
    checkOutput("ab_busy", 32'(busy), 0);
    st = 1'b1;
    stepCycle();
    checkOutput("ab_restart_addr", 32'(addr), 0);
    checkOutput("ab_restart_busy", 32'(busy), 1);
    st = 1'b0;
    stepCycle();

    // Asynchronous reset mid-run at addr=100
    applyStimulus(1'b1, 1'b1, 1'b0, 14'd200);
    for (int i = 0; i <= 100; i++) stepCycle();
    checkOutput("ar_pre_addr", 32'(addr), 100);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_addr", 32'(addr), 0);
    checkOutput("ar_valid", 32'(valid), 0);
    checkOutput("ar_done", 32'(done), 0);
    stepCycle();
    checkOutput("ar_hold_addr", 32'(addr), 0);
    checkOutput("ar_hold_busy", 32'(busy), 0);
    #2;
    rst = 1'b0;
    stepCycle();
    checkOutput("ar_rerun_busy", 32'(busy), 1);
    checkOutput("ar_rerun_addr", 32'(addr), 0);
    st = 1'b0;
    stepCycle();

    // Full one-shot run to term=12282
    applyStimulus(1'b1, 1'b1, 1'b0, 14'd12282);
    stepCycle();
    ntrans   = 0;
    seqErr   = 0;
    gotDone  = 1'b0;
    lastAddr = '0;
    for (int i = 0; i < 13000 && !gotDone; i++) begin
      if (valid) begin
        if (32'(addr) != 32'(ntrans)) seqErr++;
        ntrans++;
        lastAddr = addr;
      end
      stepCycle();
      if (done_p) gotDone = 1'b1;
    end
    checkOutput("full_done_p_seen", 32'(gotDone), 1);
    checkOutput("full_transfers", 32'(ntrans), 12283);
    checkOutput("full_last_addr", 32'(lastAddr), 12282);
    checkOutput("full_seq_errors", 32'(seqErr), 0);
    checkOutput("full_done", 32'(done), 1);
    checkOutput("full_addr", 32'(addr), 12282);
`ifdef ADDR_SEQ_PASS_CNT_EN
    checkOutput("full_pass_cnt", 32'(pass_cnt), 1);
`endif
    st = 1'b0;
    stepCycle();

    // Wrap at the top of the address space
    applyStimulus(1'b1, 1'b1, 1'b1, 14'd16383);
    stepCycle();
    checkOutput("top_first", 32'(addr), 0);
    repeat (16383) stepCycle();
    checkOutput("top_addr", 32'(addr), 16383);
    checkOutput("top_pre_wrap_p", 32'(wrap_p), 0);
    stepCycle();
    checkOutput("top_wrap_addr", 32'(addr), 0);
    checkOutput("top_wrap_p", 32'(wrap_p), 1);
    checkOutput("top_busy", 32'(busy), 1);
    checkOutput("top_done", 32'(done), 0);
    st = 1'b0;
    stepCycle();
    checkOutput("top_idle_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
